// File: rtl/hdr_pkg.sv
// Shared constants and types for the camera-to-RAM capture path.
package hdr_pkg;

  localparam int PIXEL_W      = 16;
  localparam int WORD_W       = 128;
  localparam int PIX_PER_WORD = WORD_W / PIXEL_W;
  localparam int ADDR_W       = 27;
  localparam int FRAME_PIXELS = 307200;

  // Distance between frame slots in RAM, in 16-bit pixel units (640x480).
  localparam logic [ADDR_W-1:0] FRAME_BASE_STRIDE = 27'h4B000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } wb_state_e;

  // RAM base address of a frame slot.
  function automatic logic [ADDR_W-1:0] slot_base(input logic [2:0] slot);
    return ADDR_W'(slot) * FRAME_BASE_STRIDE;
  endfunction

endpackage

// File: rtl/wr_word_fifo.sv
// First-word fall-through FIFO holding packed words ahead of the RAM port.
// full/empty are registered so wr_req comes straight from a flop.
module wr_word_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic             do_push, do_pop;

  // A push while full is accepted only when the head leaves the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign wr_nxt  = wr_ptr + PW'(do_push);
  assign rd_nxt  = rd_ptr + PW'(do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Pointers and registered occupancy flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      empty  <= (wr_nxt == rd_nxt);
      full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
    end
  end

endmodule

// File: rtl/cam_write_buffer.sv
// Packs RGB565 pixels eight to a 128-bit word, queues them, and writes them
// to consecutive RAM addresses of the selected frame slot.
module cam_write_buffer
  import hdr_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int FRAME_PIXELS = hdr_pkg::FRAME_PIXELS
) (
  input  logic              clk,
  input  logic              ui_rst_n,
  input  logic              start_frame,
  input  logic [2:0]        frame_slot,
  input  logic              pixel_valid,
  input  logic [PIXEL_W-1:0] pixel_data,
  input  logic              wr_ack,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_address,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow
);

  localparam int FRAME_WORDS = FRAME_PIXELS / PIX_PER_WORD;
  localparam int CW          = $clog2(FRAME_WORDS + 1);
  localparam int LANE_BITS   = $clog2(PIX_PER_WORD);

  wb_state_e         state;
  logic [18:0]       pix_cnt;
  logic [WORD_W-1:0] pack_word;
  logic              push_vld;
  logic [CW-1:0]     done_cnt, done_nxt;
  logic              fifo_full, fifo_empty;
  logic [WORD_W-1:0] fifo_head;
  logic              pop, drop, pix_acc, last_pix, last_word;

  assign wr_req    = ~fifo_empty;
  assign wr_data   = wr_req ? fifo_head : '0;
  assign pop       = wr_req & wr_ack;
  assign drop      = push_vld & fifo_full & ~pop;
  assign pix_acc   = (state == ACTIVE) & pixel_valid;
  assign last_pix  = (pix_cnt == 19'(FRAME_PIXELS - 1));
  // Dropped words count toward completion so FLUSH always terminates.
  assign done_nxt  = done_cnt + CW'(pop) + CW'(drop);
  assign last_word = (state == FLUSH) & pop & (done_nxt == CW'(FRAME_WORDS));

  wr_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (ui_rst_n),
    .push      (push_vld),
    .push_data (pack_word),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Capture FSM with packer, address and completion bookkeeping.
  always_ff @(posedge clk or negedge ui_rst_n) begin
    if (!ui_rst_n) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      pack_word  <= '0;
      push_vld   <= 1'b0;
      done_cnt   <= '0;
      wr_address <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      push_vld   <= 1'b0;
      if (pop) wr_address <= wr_address + 27'd8;
      case (state)
        IDLE: begin
          if (start_frame) begin
            state      <= ACTIVE;
            busy       <= 1'b1;
            wr_address <= slot_base(frame_slot);
            pix_cnt    <= '0;
            pack_word  <= '0;
            done_cnt   <= '0;
            overflow   <= 1'b0;
          end
        end
        ACTIVE, FLUSH: begin
          done_cnt <= done_nxt;
          if (drop) overflow <= 1'b1;
          if (pix_acc) begin
            pack_word[pix_cnt[LANE_BITS-1:0]*PIXEL_W +: PIXEL_W] <= pixel_data;
            pix_cnt <= pix_cnt + 19'd1;
            // Word complete: hand it to the FIFO next cycle, while lane 0
            // of the following word may already overwrite the packer.
            if (&pix_cnt[LANE_BITS-1:0]) push_vld <= 1'b1;
            if (last_pix) state <= FLUSH;
          end
          if (last_word) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_write_buffer.sv
// Directed bench for cam_write_buffer, using a short frame to keep runs brief.
module tb_cam_write_buffer;

  localparam int DEPTH = 16;
  localparam int FP    = 256;
  localparam int FW    = FP / 8;

  logic         clk = 1'b0;
  logic         ui_rst_n;
  logic         start_frame;
  logic [2:0]   frame_slot;
  logic         pixel_valid;
  logic [15:0]  pixel_data;
  logic         wr_ack;
  logic         wr_req;
  logic [26:0]  wr_address;
  logic [127:0] wr_data;
  logic         busy, frame_done, overflow;

  int total = 0;
  int bad   = 0;

  logic [15:0] pix_q [$];

  always #5 clk = ~clk;

  cam_write_buffer #(.FIFO_DEPTH(DEPTH), .FRAME_PIXELS(FP)) dut (
    .clk         (clk),
    .ui_rst_n    (ui_rst_n),
    .start_frame (start_frame),
    .frame_slot  (frame_slot),
    .pixel_valid (pixel_valid),
    .pixel_data  (pixel_data),
    .wr_ack      (wr_ack),
    .wr_req      (wr_req),
    .wr_address  (wr_address),
    .wr_data     (wr_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .overflow    (overflow)
  );

  function automatic logic [127:0] exp_word(input int w);
    logic [127:0] r = '0;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = pix_q[w*8+i];
    return r;
  endfunction

  task automatic reset_dut();
    ui_rst_n = 1'b0; start_frame = 1'b0; frame_slot = '0;
    pixel_valid = 1'b0; pixel_data = '0; wr_ack = 1'b0;
    repeat (2) @(negedge clk);
    ui_rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic start(input logic [2:0] slot);
    start_frame = 1'b1; frame_slot = slot;
    @(negedge clk);
    start_frame = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    total++; if (wr_req !== 1'b0)      begin bad++; $display("FAIL rst_wr_req got %b want 0", wr_req); end
    total++; if (wr_address !== 27'h0) begin bad++; $display("FAIL rst_addr got %h want 0", wr_address); end
    total++; if (wr_data !== '0)       begin bad++; $display("FAIL rst_data got %h want 0", wr_data); end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
    total++; if (frame_done !== 1'b0)  begin bad++; $display("FAIL rst_frame_done got %b want 0", frame_done); end
    total++; if (overflow !== 1'b0)    begin bad++; $display("FAIL rst_overflow got %b want 0", overflow); end
  endtask

  task automatic test_first_word();
    reset_dut(); pix_q.delete();
    start(3'd2);
    total++; if (wr_address !== 27'h96000) begin bad++; $display("FAIL fw_base got %h want 96000", wr_address); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fw_busy got %b want 1", busy); end
    for (int i = 0; i < 8; i++) begin
      pixel_valid = 1'b1; pixel_data = 16'(i + 1); pix_q.push_back(pixel_data);
      @(negedge clk);
    end
    pixel_valid = 1'b0;
    total++; if (wr_req !== 1'b0) begin bad++; $display("FAIL fw_early_req got %b want 0", wr_req); end
    @(negedge clk);
    total++; if (wr_req !== 1'b1) begin bad++; $display("FAIL fw_req got %b want 1", wr_req); end
    total++; if (wr_data !== 128'h0008_0007_0006_0005_0004_0003_0002_0001)
      begin bad++; $display("FAIL fw_data got %h want 0008..0001", wr_data); end
    total++; if (wr_address !== 27'h96000) begin bad++; $display("FAIL fw_addr got %h want 96000", wr_address); end
  endtask

  task automatic test_full_frame();
    int acks = 0, fd = 0, pix = 0;
    bit done = 0;
    logic [26:0] last_addr = '0;
    reset_dut(); pix_q.delete();
    start(3'd2);
    wr_ack = 1'b1;
    for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
      if (frame_done) begin fd++; done = 1; end
      if (wr_req) begin
        total++;
        if (acks >= FW) begin bad++; $display("FAIL ff_extra_word got %0d want <%0d", acks + 1, FW); end
        else if (wr_data !== exp_word(acks) || wr_address !== 27'h96000 + 27'(8 * acks)) begin
          bad++; $display("FAIL ff_word%0d got %h@%h want %h@%h", acks, wr_data, wr_address,
                          exp_word(acks), 27'h96000 + 27'(8 * acks));
        end
        last_addr = wr_address; acks++;
      end
      // pixel_valid stays high past the frame end; those pixels must be ignored
      pixel_valid = 1'b1; pixel_data = 16'(32'hA000 + pix);
      if (pix < FP) pix_q.push_back(pixel_data);
      pix++;
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      if (frame_done) fd++;
      if (wr_req) acks++;
      @(negedge clk);
    end
    pixel_valid = 1'b0; wr_ack = 1'b0;
    total++; if (!done) begin bad++; $display("FAIL ff_timeout got no frame_done want done"); end
    total++; if (acks != FW) begin bad++; $display("FAIL ff_acks got %0d want %0d", acks, FW); end
    total++; if (last_addr !== 27'h960F8) begin bad++; $display("FAIL ff_last_addr got %h want 960f8", last_addr); end
    total++; if (fd != 1) begin bad++; $display("FAIL ff_done_pulses got %0d want 1", fd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ff_busy got %b want 0", busy); end
    total++; if (wr_req !== 1'b0) begin bad++; $display("FAIL ff_idle_req got %b want 0", wr_req); end
  endtask

  task automatic test_overflow();
    int got = 0, fd = 0, pix = 0, widx;
    bit done = 0;
    reset_dut(); pix_q.delete();
    for (int i = 0; i < FP; i++) pix_q.push_back(16'(i * 7 + 5));
    start(3'd1);
    wr_ack = 1'b0;
    for (; pix < (DEPTH + 1) * 8; pix++) begin
      pixel_valid = 1'b1; pixel_data = pix_q[pix];
      @(negedge clk);
    end
    pixel_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ov_flag got %b want 1", overflow); end
    total++; if (wr_req !== 1'b1) begin bad++; $display("FAIL ov_req got %b want 1", wr_req); end
    total++; if (wr_data !== exp_word(0)) begin bad++; $display("FAIL ov_head got %h want %h", wr_data, exp_word(0)); end
    total++; if (wr_address !== 27'h4B000) begin bad++; $display("FAIL ov_addr got %h want 4b000", wr_address); end
    wr_ack = 1'b1;
    for (int cyc = 0; cyc < 800 && !done; cyc++) begin
      if (frame_done) begin fd++; done = 1; end
      if (wr_req) begin
        widx = (got < DEPTH) ? got : got + 1;   // word DEPTH was dropped
        total++;
        if (widx >= FW) begin bad++; $display("FAIL ov_extra_word got %0d want <%0d", widx, FW); end
        else if (wr_data !== exp_word(widx)) begin
          bad++; $display("FAIL ov_word%0d got %h want %h", widx, wr_data, exp_word(widx));
        end
        got++;
      end
      pixel_valid = (pix < FP);
      if (pix < FP) begin pixel_data = pix_q[pix]; pix++; end
      @(negedge clk);
    end
    pixel_valid = 1'b0; wr_ack = 1'b0;
    total++; if (!done) begin bad++; $display("FAIL ov_timeout got no frame_done want done"); end
    total++; if (got != FW - 1) begin bad++; $display("FAIL ov_acks got %0d want %0d", got, FW - 1); end
    total++; if (fd != 1) begin bad++; $display("FAIL ov_done_pulses got %0d want 1", fd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ov_busy got %b want 0", busy); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ov_sticky got %b want 1", overflow); end
    start(3'd0);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ov_clear got %b want 0", overflow); end
  endtask

  task automatic test_ignore_start();
    reset_dut(); pix_q.delete();
    start(3'd3);
    for (int i = 0; i < 8; i++) begin
      pixel_valid = 1'b1; pixel_data = 16'(32'h3000 + i); pix_q.push_back(pixel_data);
      start_frame = (i == 3); frame_slot = 3'd5;
      @(negedge clk);
    end
    start_frame = 1'b0; pixel_valid = 1'b0;
    @(negedge clk);
    total++; if (wr_req !== 1'b1) begin bad++; $display("FAIL is_req got %b want 1", wr_req); end
    total++; if (wr_address !== 27'hE1000) begin bad++; $display("FAIL is_addr got %h want e1000", wr_address); end
    total++; if (wr_data !== exp_word(0)) begin bad++; $display("FAIL is_data got %h want %h", wr_data, exp_word(0)); end
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    total++; if (wr_address !== 27'hE1008) begin bad++; $display("FAIL is_advance got %h want e1008", wr_address); end
    total++; if (wr_req !== 1'b0) begin bad++; $display("FAIL is_drained got %b want 0", wr_req); end
  endtask

  task automatic test_reset_flush();
    int acks = 0, pix = 0, post = 0;
    reset_dut(); pix_q.delete();
    start(3'd4);
    for (int cyc = 0; cyc < 600 && post < 6; cyc++) begin
      wr_ack = (acks < FW - 5);
      if (wr_req && wr_ack) acks++;
      pixel_valid = (pix < FP);
      if (pix < FP) begin pixel_data = 16'(pix); pix++; end
      else post++;
      @(negedge clk);
    end
    wr_ack = 1'b0; pixel_valid = 1'b0;
    total++; if (busy !== 1'b1 || wr_req !== 1'b1)
      begin bad++; $display("FAIL rf_pending got busy=%b req=%b want 1/1", busy, wr_req); end
    total++; if (wr_address !== 27'h12C0D8) begin bad++; $display("FAIL rf_addr got %h want 12c0d8", wr_address); end
    #2 ui_rst_n = 1'b0;
    #1;
    total++; if (wr_req !== 1'b0) begin bad++; $display("FAIL rf_async_req got %b want 0", wr_req); end
    total++; if (busy !== 1'b0 || wr_address !== 27'h0)
      begin bad++; $display("FAIL rf_async_state got busy=%b addr=%h want 0/0", busy, wr_address); end
    @(negedge clk);
    ui_rst_n = 1'b1;
    @(negedge clk);
    pix_q.delete();
    start(3'd6);
    total++; if (wr_address !== 27'h1C2000) begin bad++; $display("FAIL rf_new_base got %h want 1c2000", wr_address); end
    total++; if (wr_req !== 1'b0 || overflow !== 1'b0)
      begin bad++; $display("FAIL rf_clean got req=%b ovf=%b want 0/0", wr_req, overflow); end
    for (int i = 0; i < 8; i++) begin
      pixel_valid = 1'b1; pixel_data = 16'(32'h5A00 + i); pix_q.push_back(pixel_data);
      @(negedge clk);
    end
    pixel_valid = 1'b0;
    @(negedge clk);
    total++; if (wr_req !== 1'b1 || wr_data !== exp_word(0))
      begin bad++; $display("FAIL rf_first_word got %b/%h want 1/%h", wr_req, wr_data, exp_word(0)); end
  endtask

  task automatic test_random_stall();
    int got = 0, fd = 0, pix = 0;
    bit done = 0, hold = 0;
    logic [127:0] hd = '0;
    logic [26:0]  ha = '0;
    reset_dut(); pix_q.delete();
    for (int i = 0; i < FP; i++) pix_q.push_back(16'($urandom));
    start(3'd7);
    for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
      if (frame_done) begin fd++; done = 1; end
      if (hold) begin
        total++;
        if (wr_req !== 1'b1 || wr_data !== hd || wr_address !== ha) begin
          bad++; $display("FAIL rs_stable got %b/%h@%h want 1/%h@%h", wr_req, wr_data, wr_address, hd, ha);
        end
      end
      wr_ack = 1'($urandom_range(0, 1));
      hold = 0;
      if (wr_req) begin
        if (wr_ack) begin
          total++;
          if (got >= FW) begin bad++; $display("FAIL rs_extra_word got %0d want <%0d", got + 1, FW); end
          else if (wr_data !== exp_word(got) || wr_address !== 27'h20D000 + 27'(8 * got)) begin
            bad++; $display("FAIL rs_word%0d got %h@%h want %h@%h", got, wr_data, wr_address,
                            exp_word(got), 27'h20D000 + 27'(8 * got));
          end
          got++;
        end else begin
          hold = 1; hd = wr_data; ha = wr_address;
        end
      end
      pixel_valid = (pix < FP) && ($urandom_range(0, 1) == 1);
      if (pixel_valid) begin pixel_data = pix_q[pix]; pix++; end
      @(negedge clk);
    end
    wr_ack = 1'b0; pixel_valid = 1'b0;
    total++; if (!done) begin bad++; $display("FAIL rs_timeout got no frame_done want done"); end
    total++; if (got != FW) begin bad++; $display("FAIL rs_acks got %0d want %0d", got, FW); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rs_overflow got %b want 0", overflow); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rs_busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_full_frame();
    test_overflow();
    test_ignore_start();
    test_reset_flush();
    test_random_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
